// File: rtl/pc_fetch_unit_if.sv
// Bundles the fetch unit's control inputs and IF/ID outputs.
// The master drives redirects, stall and the instruction word; the slave is the fetch unit.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned COUNT_W = 16
);
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               jump;
  logic [ADDR_W-1:0]  jump_target;
  logic               exception;
  logic [INSTR_W-1:0] instr_in;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_valid;
  logic               misalign;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, exception, instr_in,
    input  pc, if_pc, if_instr, if_valid, misalign, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, exception, instr_in,
    output pc, if_pc, if_instr, if_valid, misalign, fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and IF/ID register: sequential/branch/jump/exception next-PC selection,
// stall hold with a one-deep buffered redirect, and optional branch-delay-slot behaviour.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       INSTR_W      = 32,
  parameter int unsigned       INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'('h180),
  parameter bit                DELAY_SLOT   = 1'b1,
  parameter int unsigned       COUNT_W      = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  pc_fetch_unit_if.slave  fetch_bus
);

  localparam logic [ADDR_W-1:0]  AlignMask = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0]  PcStep    = ADDR_W'(INSTR_BYTES);
  localparam logic [COUNT_W-1:0] CountMax  = '1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [INSTR_W-1:0] r_if_instr;
  logic               r_if_valid;
  logic               r_misalign;
  logic [COUNT_W-1:0] r_fetch_count;
  logic               r_pend_valid;
  logic [ADDR_W-1:0]  r_pend_target;
  logic               r_pend_mis;

  logic               w_req;
  logic [ADDR_W-1:0]  w_raw_target;
  logic [ADDR_W-1:0]  w_target;
  logic               w_target_mis;
  logic               w_apply;
  logic [ADDR_W-1:0]  w_apply_target;
  logic               w_apply_mis;
  logic               w_valid_next;

  // Jump wins over a simultaneous taken branch.
  assign w_req          = fetch_bus.jump | fetch_bus.branch_taken;
  assign w_raw_target   = fetch_bus.jump ? fetch_bus.jump_target : fetch_bus.branch_target;
  assign w_target       = w_raw_target & ~AlignMask;
  assign w_target_mis   = |(w_raw_target & AlignMask);

  // A buffered redirect outranks whatever request is live on the unstalling edge.
  assign w_apply        = r_pend_valid | w_req;
  assign w_apply_target = r_pend_valid ? r_pend_target : w_target;
  assign w_apply_mis    = r_pend_valid ? r_pend_mis : w_target_mis;
  assign w_valid_next   = DELAY_SLOT | ~w_apply;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_VECTOR;
      r_if_pc       <= '0;
      r_if_instr    <= '0;
      r_if_valid    <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_pend_mis    <= 1'b0;
    end else if (fetch_bus.exception) begin
      r_pc         <= EXC_VECTOR;
      r_if_valid   <= 1'b0;
      r_misalign   <= 1'b0;
      r_pend_valid <= 1'b0;
    end else if (fetch_bus.stall) begin
      r_misalign <= 1'b0;
      if (w_req && !r_pend_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_target;
        r_pend_mis    <= w_target_mis;
      end
    end else begin
      r_if_pc      <= r_pc;
      r_if_instr   <= fetch_bus.instr_in;
      r_if_valid   <= w_valid_next;
      r_pend_valid <= 1'b0;
      r_pc         <= w_apply ? w_apply_target : r_pc + PcStep;
      r_misalign   <= w_apply & w_apply_mis;
      if (w_valid_next && r_fetch_count != CountMax) begin
        r_fetch_count <= r_fetch_count + 1'b1;
      end
    end
  end

  assign fetch_bus.pc          = r_pc;
  assign fetch_bus.if_pc       = r_if_pc;
  assign fetch_bus.if_instr    = r_if_instr;
  assign fetch_bus.if_valid    = r_if_valid;
  assign fetch_bus.misalign    = r_misalign;
  assign fetch_bus.fetch_count = r_fetch_count;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-register program counter.
- Owns the PC and drives the instruction-memory address.
- Selects the next PC: sequential, branch, jump or exception vector.
- Holds the PC under stall and buffers redirects that arrive during a stall.
- Registers the fetched instruction into an IF/ID stage with a valid bit; optional MIPS branch-delay-slot semantics.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- INSTR_W, 32, instruction width.
- INSTR_BYTES, 4, sequential PC increment; power of two.
- RESET_VECTOR, 32'h00000000, PC value at reset.
- EXC_VECTOR, 32'h00000180, PC loaded on Exception.
- DELAY_SLOT, 1, 1 = keep the instruction after a redirect; 0 = squash it.
- COUNT_W, 16, width of the fetch counter.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Stall  input  1  hold PC and IF/ID registers.
- Branch_taken  input  1  branch resolved taken this cycle.
- Branch_target  input  ADDR_W  branch destination.
- Jump  input  1  unconditional jump request.
- Jump_target  input  ADDR_W  jump destination.
- Exception  input  1  redirect to EXC_VECTOR and squash.
- Instr_in  input  INSTR_W  instruction read from memory at PC, combinational.
- PC  output  ADDR_W  current fetch address to instruction memory.
- IF_PC  output  ADDR_W  address of the instruction held in IF/ID.
- IF_Instr  output  INSTR_W  registered instruction.
- IF_Valid  output  1  IF/ID holds a live instruction.
- Misalign  output  1  one-cycle pulse: a redirect target had nonzero low bits.
- Fetch_count  output  COUNT_W  number of valid fetches, saturating.

Behaviour:
- Reset low (asynchronous): PC=RESET_VECTOR, IF_PC=0, IF_Instr=0, IF_Valid=0, Misalign=0, Fetch_count=0, pending redirect cleared. The first fetch occurs on the first rising edge after Reset rises.
- All state updates on the rising edge of Clk. PC to Instr_in is combinational; instruction latency PC to IF_Instr is 1 cycle.
- Redirect request this cycle: req = Jump | Branch_taken. Target = Jump_target if Jump is set, else Branch_target. Jump has priority when both are asserted.
- Priority per edge:
  1. Exception.
  2. Pending redirect.
  3. Live request.
  4. Sequential.
- Exception (acts even when Stall=1):
  - PC <= EXC_VECTOR.
  - IF_Valid <= 0; IF_PC and IF_Instr may update but are don't-care.
  - Pending redirect cleared.
- Stall=1, no Exception:
  - PC, IF_PC, IF_Instr, IF_Valid and Fetch_count hold.
  - If req is set and no redirect is pending, capture the target into the pending register (pend_valid=1).
  - A request arriving while a redirect is already pending is ignored.
- Stall=0, no Exception:
  - IF_PC <= PC, IF_Instr <= Instr_in, IF_Valid <= 1.
  - PC <= pending target if pend_valid, else the live target if req, else PC+INSTR_BYTES.
  - pend_valid cleared.
- DELAY_SLOT=0: on any edge where a redirect is applied (pending or live), IF_Valid <= 0, squashing the wrong-path instruction.
- DELAY_SLOT=1: on a redirect edge, IF_Valid <= 1, so the delay-slot instruction proceeds.
- Alignment:
  - Applied targets have their low log2(INSTR_BYTES) bits forced to 0.
  - If any forced bit was 1, Misalign=1 for exactly the cycle following the applying edge; otherwise Misalign=0.
  - The check is done at capture for pending targets and reported at apply.
- Arithmetic: PC+INSTR_BYTES wraps modulo 2^ADDR_W, with no flag.
- Fetch_count increments on every edge where IF_Valid is written 1 and saturates at 2^COUNT_W-1.
- Reset asserted mid-stall or with a redirect pending: all state returns to reset values immediately; the pending redirect is lost.

Test Plan:
- Reset then 4 free-running cycles, Instr_in = 0x24010001 (constant) -> PC sequence 0,4,8,12,16. IF_PC lags by one cycle. IF_Valid=1 from the first edge. Fetch_count=4.
- Branch_taken=1, Branch_target=0x40 at PC=0x10:
  - DELAY_SLOT=1 -> next PC=0x40 and IF_PC=0x10 with IF_Valid=1.
  - DELAY_SLOT=0 -> same PC, but IF_Valid=0 for that cycle.
- Stall=1 for 3 cycles with Jump=1, Jump_target=0x100 in the first stalled cycle only -> PC held; then the first unstalled edge gives PC=0x100 (pending redirect consumed).
- Jump (target 0x200) and Branch_taken (target 0x300) in the same cycle -> PC=0x200.
- Exception=1 while Stall=1 with a redirect pending -> PC=0x180, IF_Valid=0, pending cleared; the next unstalled edge gives PC=0x184.
- Edge cases:
  - Branch_target=0x43 -> PC=0x40 and a one-cycle Misalign pulse.
  - PC=0xFFFFFFFC sequential -> PC=0x0.
  - Reset asserted mid-stall -> all outputs at reset values asynchronously.
